// File: rtl/fcvt_sched.sv
// Issue scheduler for the shared int-to-float converter: round-robin arbitration
// of two request ports, a 2-stage tag/format shadow pipeline, and valid/ready output.
module fcvt_sched #(
  parameter int unsigned TAG_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [64:0]       req0_A,
  input  logic [64:0]       req1_A,
  input  logic              req0_isS,
  input  logic              req1_isS,
  input  logic [1:0]        req0_fmt,
  input  logic [1:0]        req1_fmt,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              cv_en,
  output logic              cv_clkEn,
  output logic [64:0]       cv_A,
  output logic              cv_isS,
  output logic              cv_toSNG,
  output logic              cv_toDBL,
  output logic              cv_toEXT,
  input  logic [81:0]       cv_res,
  input  logic [1:0]        cv_rtyp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [81:0]       out_res,
  output logic [1:0]        out_rtyp,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_inv,
  output logic [1:0]        busy
);

  localparam logic [1:0] PTYPE_EXT = 2'd2;
  localparam logic [1:0] FMT_INV   = 2'd3;

  logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic             s1_inv_q, s1_inv_d, s2_inv_q, s2_inv_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
  logic             lp_q, lp_d;

  logic       stall, can_issue, gnt0, gnt1, gnt;
  logic [1:0] fmt_sel;

  assign stall     = s2_v_q & ~out_ready;
  assign can_issue = ~stall & ~flush & ~rst;
  // lp holds the last granted port; on contention the other port wins.
  assign gnt0      = can_issue & req0_valid & (~req1_valid | lp_q);
  assign gnt1      = can_issue & req1_valid & (~req0_valid | ~lp_q);
  assign gnt       = gnt0 | gnt1;
  assign fmt_sel   = gnt1 ? req1_fmt : req0_fmt;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    cv_en    = gnt;
    cv_clkEn = ~stall;
    cv_A     = '0;
    cv_isS   = 1'b0;
    cv_toSNG = 1'b0;
    cv_toDBL = 1'b0;
    cv_toEXT = 1'b0;
    if (gnt) begin
      cv_A     = gnt1 ? req1_A : req0_A;
      cv_isS   = gnt1 ? req1_isS : req0_isS;
      cv_toSNG = (fmt_sel == 2'd0);
      cv_toDBL = (fmt_sel == 2'd1);
      cv_toEXT = (fmt_sel == 2'd2);
    end
  end

  always_comb begin
    s1_v_d   = s1_v_q;
    s1_inv_d = s1_inv_q;
    s1_tag_d = s1_tag_q;
    s2_v_d   = s2_v_q;
    s2_inv_d = s2_inv_q;
    s2_tag_d = s2_tag_q;
    lp_d     = gnt ? gnt1 : lp_q;
    // Shadow stages move only when the converter's clock-enable is high.
    if (!stall) begin
      s1_v_d   = gnt;
      s1_inv_d = gnt & (fmt_sel == FMT_INV);
      s1_tag_d = gnt1 ? req1_tag : req0_tag;
      s2_v_d   = s1_v_q;
      s2_inv_d = s1_inv_q;
      s2_tag_d = s1_tag_q;
    end
    if (flush) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_inv_q <= 1'b0;
      s1_tag_q <= '0;
      s2_v_q   <= 1'b0;
      s2_inv_q <= 1'b0;
      s2_tag_q <= '0;
      lp_q     <= 1'b1;
    end else begin
      s1_v_q   <= s1_v_d;
      s1_inv_q <= s1_inv_d;
      s1_tag_q <= s1_tag_d;
      s2_v_q   <= s2_v_d;
      s2_inv_q <= s2_inv_d;
      s2_tag_q <= s2_tag_d;
      lp_q     <= lp_d;
    end
  end

  always_comb begin
    out_valid = s2_v_q;
    out_inv   = s2_v_q & s2_inv_q;
    out_tag   = s2_v_q ? s2_tag_q : '0;
    out_res   = '0;
    out_rtyp  = '0;
    if (s2_v_q) begin
      out_res  = s2_inv_q ? '0 : cv_res;
      out_rtyp = s2_inv_q ? PTYPE_EXT : cv_rtyp;
    end
  end

  assign busy = {1'b0, s1_v_q} + {1'b0, s2_v_q};

endmodule
